// File: rtl/xillybus_mem_bank.sv
// ---------------------------------------------------------------------------
// xillybus_mem_bank
//
// Memory endpoint for a seekable Xillybus stream. The width and depth are
// set by parameters. The host sees a FIFO-like read side and write side. Each
// side has its own pointer, and both pointers are loaded by a seek. The
// application gets a registered read port and a strobe for every host write
// that is accepted.
//
// Parameters
//   DATA_W : word width in bits. Legal values are 8, 16 and 32.
//   ADDR_W : address width. DEPTH = 2**ADDR_W words.
//
// Ports (all synchronous to bus_clk)
//   bus_clk              : the single clock
//   quiesce              : synchronous active-high reset from the core
//   user_r_rden          : host read request
//   user_r_empty         : no read data available (read pointer at end of memory)
//   user_r_data          : read word, valid the cycle after an accepted rden
//   user_r_eof           : end of file, asserted together with empty
//   user_r_open          : read side open (informational only)
//   user_w_wren          : host write strobe
//   user_w_full          : write side cannot accept data (write pointer at end)
//   user_w_data          : write word
//   user_w_open          : write side open (informational only)
//   user_mem_addr        : seek address
//   user_mem_addr_update : one-cycle pulse that loads both pointers
//   app_addr             : application read address
//   app_rdata            : mem[app_addr], registered
//   app_wr_strobe        : one-cycle pulse per accepted host write
//   app_wr_addr          : address of that write
//
// Configuration macro
//   XILLYBUS_MEM_WRAP_EN : when defined, the pointers wrap modulo DEPTH and
//                          empty/eof/full are tied low. When it is not defined,
//                          end of memory raises empty+eof (read side) or full
//                          (write side) until the next seek or reset.
// ---------------------------------------------------------------------------
module xillybus_mem_bank #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
) (
    input  logic              bus_clk,
    input  logic              quiesce,
    input  logic              user_r_rden,
    output logic              user_r_empty,
    output logic [DATA_W-1:0] user_r_data,
    output logic              user_r_eof,
    input  logic              user_r_open,
    input  logic              user_w_wren,
    output logic              user_w_full,
    input  logic [DATA_W-1:0] user_w_data,
    input  logic              user_w_open,
    input  logic [ADDR_W-1:0] user_mem_addr,
    input  logic              user_mem_addr_update,
    input  logic [ADDR_W-1:0] app_addr,
    output logic [DATA_W-1:0] app_rdata,
    output logic              app_wr_strobe,
    output logic [ADDR_W-1:0] app_wr_addr
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0]   PTR_ONE = 1;
    localparam logic [ADDR_W-1:0] IDX_ONE = 1;

    // Storage. It is not reset, so that it can map onto block RAM.
    logic [DATA_W-1:0] r_mem [DEPTH];

    // Pointers. Bit ADDR_W is the end-of-memory flag, and the low bits index
    // the RAM.
    logic [ADDR_W:0] r_rdPtr;
    logic [ADDR_W:0] r_wrPtr;

    logic [ADDR_W:0] w_rdBase;
    logic [ADDR_W:0] w_wrBase;
    logic [ADDR_W:0] w_rdNext;
    logic [ADDR_W:0] w_wrNext;
    logic            w_empty;
    logic            w_full;
    logic            w_rdEn;
    logic            w_wrEn;
    logic            w_unusedOpen;

    // The open flags carry no behaviour. The core seeks on open instead.
    assign w_unusedOpen = user_r_open ^ user_w_open;

    // A seek in the same cycle as an access redirects that access, so the
    // address used this cycle is the seek address, not the stored pointer.
    assign w_rdBase = user_mem_addr_update ? {1'b0, user_mem_addr} : r_rdPtr;
    assign w_wrBase = user_mem_addr_update ? {1'b0, user_mem_addr} : r_wrPtr;

`ifdef XILLYBUS_MEM_WRAP_EN
    logic w_unusedPtrMsb;

    // Wrapping mode. The index rolls over and the end flag never sets.
    assign w_empty  = 1'b0;
    assign w_full   = 1'b0;
    assign w_rdNext = {1'b0, w_rdBase[ADDR_W-1:0] + IDX_ONE};
    assign w_wrNext = {1'b0, w_wrBase[ADDR_W-1:0] + IDX_ONE};
    assign w_unusedPtrMsb = w_rdBase[ADDR_W] ^ w_wrBase[ADDR_W];
`else
    // End-of-memory mode. Incrementing past the last word sets bit ADDR_W,
    // and that bit is the empty/full condition. The guards below stop the
    // pointer from ever moving beyond DEPTH.
    assign w_empty  = r_rdPtr[ADDR_W];
    assign w_full   = r_wrPtr[ADDR_W];
    assign w_rdNext = w_rdBase + PTR_ONE;
    assign w_wrNext = w_wrBase + PTR_ONE;
`endif

    assign user_r_empty = w_empty;
    assign user_r_eof   = w_empty;
    assign user_w_full  = w_full;

    // An access is refused at end of memory. A concurrent seek counts as a
    // fresh position, so it re-enables the access.
    assign w_rdEn = user_r_rden && (user_mem_addr_update || !w_empty);
    assign w_wrEn = user_w_wren && (user_mem_addr_update || !w_full);

    // Pointer update. A seek loads both pointers, and a side that also
    // accesses this cycle moves one past the seek address.
    always_ff @(posedge bus_clk) begin
        if (quiesce) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
        end else begin
            if (w_rdEn) begin
                r_rdPtr <= w_rdNext;
            end else if (user_mem_addr_update) begin
                r_rdPtr <= w_rdBase;
            end
            if (w_wrEn) begin
                r_wrPtr <= w_wrNext;
            end else if (user_mem_addr_update) begin
                r_wrPtr <= w_wrBase;
            end
        end
    end

    // RAM write port. quiesce does not gate it, so a write issued in the
    // same cycle as quiesce still lands in memory.
    always_ff @(posedge bus_clk) begin
        if (w_wrEn) begin
            r_mem[w_wrBase[ADDR_W-1:0]] <= user_w_data;
        end
    end

    // Host read port. A read at the same address as a write in the same
    // cycle returns the old contents (read-first). quiesce clears the output
    // register, so an in-flight read returns 0.
    always_ff @(posedge bus_clk) begin
        if (quiesce) begin
            user_r_data <= '0;
        end else if (w_rdEn) begin
            user_r_data <= r_mem[w_rdBase[ADDR_W-1:0]];
        end
    end

    // Application read port. It reads every cycle and is also read-first.
    always_ff @(posedge bus_clk) begin
        if (quiesce) begin
            app_rdata <= '0;
        end else begin
            app_rdata <= r_mem[app_addr];
        end
    end

    // Write notification to the application. It fires one cycle after each
    // accepted write and reports the address that was written.
    always_ff @(posedge bus_clk) begin
        if (quiesce) begin
            app_wr_strobe <= 1'b0;
            app_wr_addr   <= '0;
        end else begin
            app_wr_strobe <= w_wrEn;
            if (w_wrEn) begin
                app_wr_addr <= w_wrBase[ADDR_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_xillybus_mem_bank.sv
// ---------------------------------------------------------------------------
// tb_xillybus_mem_bank
//
// Scoreboard bench for xillybus_mem_bank with DATA_W=32 and ADDR_W=5.
// The stimulus task applies one cycle of inputs on the falling edge. It
// advances an integer-pointer reference model and pushes the state expected
// after the next rising edge. A separate monitor pops one entry per cycle,
// shortly after the rising edge. Each app_wr_strobe it sees pops the
// expected write address from its own queue.
// ---------------------------------------------------------------------------
module tb_xillybus_mem_bank;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 1 << ADDR_W;
`ifdef XILLYBUS_MEM_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic              bus_clk = 1'b0;
    logic              quiesce = 1'b1;
    logic              user_r_rden = 1'b0;
    logic              user_r_empty;
    logic [DATA_W-1:0] user_r_data;
    logic              user_r_eof;
    logic              user_r_open = 1'b1;
    logic              user_w_wren = 1'b0;
    logic              user_w_full;
    logic [DATA_W-1:0] user_w_data = '0;
    logic              user_w_open = 1'b1;
    logic [ADDR_W-1:0] user_mem_addr = '0;
    logic              user_mem_addr_update = 1'b0;
    logic [ADDR_W-1:0] app_addr = '0;
    logic [DATA_W-1:0] app_rdata;
    logic              app_wr_strobe;
    logic [ADDR_W-1:0] app_wr_addr;

    xillybus_mem_bank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .bus_clk              (bus_clk),
        .quiesce              (quiesce),
        .user_r_rden          (user_r_rden),
        .user_r_empty         (user_r_empty),
        .user_r_data          (user_r_data),
        .user_r_eof           (user_r_eof),
        .user_r_open          (user_r_open),
        .user_w_wren          (user_w_wren),
        .user_w_full          (user_w_full),
        .user_w_data          (user_w_data),
        .user_w_open          (user_w_open),
        .user_mem_addr        (user_mem_addr),
        .user_mem_addr_update (user_mem_addr_update),
        .app_addr             (app_addr),
        .app_rdata            (app_rdata),
        .app_wr_strobe        (app_wr_strobe),
        .app_wr_addr          (app_wr_addr)
    );

    always #5 bus_clk = ~bus_clk;

    typedef struct {
        logic [DATA_W-1:0] rdata;
        logic [DATA_W-1:0] app;
        bit                rdKnown;
        bit                appKnown;
        bit                empty;
        bit                full;
        bit                strobe;
    } exp_t;

    exp_t expQ[$];
    int   wrAddrQ[$];

    int checkCount = 0;
    int errorCount = 0;

    // Reference model state. It holds plain integer positions 0..DEPTH and
    // the memory image as the host expects it.
    int                mRd = 0;
    int                mWr = 0;
    logic [DATA_W-1:0] mMem [DEPTH];
    bit                mValid [DEPTH];
    logic [DATA_W-1:0] mRdata = '0;
    bit                mRdKnown = 1'b0;
    logic [ADDR_W-1:0] curApp = '0;

    // Compare one observed value against its expected value and count it.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs and advance the model by that cycle.
    task automatic applyStimulus(input bit q, input bit rden, input bit wren,
                                 input logic [DATA_W-1:0] wdata, input bit upd,
                                 input logic [ADDR_W-1:0] uaddr, input logic [ADDR_W-1:0] aaddr);
        exp_t e;
        bit   full, empty, wrAcc, rdAcc;
        int   wA, rA;
        @(negedge bus_clk);
        quiesce = q;
        user_r_rden = rden;
        user_w_wren = wren;
        user_w_data = wdata;
        user_mem_addr_update = upd;
        user_mem_addr = uaddr;
        app_addr = aaddr;

        full  = !WRAP && (mWr == DEPTH);
        empty = !WRAP && (mRd == DEPTH);
        wrAcc = wren && (upd || !full);
        rdAcc = rden && (upd || !empty);
        wA = upd ? int'(uaddr) : mWr;
        rA = upd ? int'(uaddr) : mRd;

        e.strobe = !q && wrAcc;
        if (q) begin
            mRdata = '0;
            mRdKnown = 1'b1;
            e.app = '0;
            e.appKnown = 1'b1;
            mRd = 0;
            mWr = 0;
        end else begin
            if (rdAcc) begin
                mRdata = mMem[rA];
                mRdKnown = mValid[rA];
            end
            e.app = mMem[aaddr];
            e.appKnown = mValid[aaddr];
            mRd = rdAcc ? rA + 1 : rA;
            mWr = wrAcc ? wA + 1 : wA;
            if (WRAP) begin
                mRd = mRd % DEPTH;
                mWr = mWr % DEPTH;
            end
        end
        if (wrAcc) begin
            mMem[wA] = wdata;
            mValid[wA] = 1'b1;
        end
        if (e.strobe) wrAddrQ.push_back(wA);
        e.rdata = mRdata;
        e.rdKnown = mRdKnown;
        e.empty = !WRAP && (mRd == DEPTH);
        e.full  = !WRAP && (mWr == DEPTH);
        expQ.push_back(e);
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, '0, 0, '0, curApp);
    endtask
    task automatic seek(input logic [ADDR_W-1:0] a);
        applyStimulus(0, 0, 0, '0, 1, a, curApp);
    endtask
    task automatic hostWrite(input logic [DATA_W-1:0] d);
        applyStimulus(0, 0, 1, d, 0, '0, curApp);
    endtask
    task automatic hostRead();
        applyStimulus(0, 1, 0, '0, 0, '0, curApp);
    endtask

    // Monitor. It pops one expectation per cycle just after the rising edge,
    // and it pops the write-address queue whenever the DUT raises its strobe.
    exp_t mon;
    initial begin
        forever begin
            @(posedge bus_clk);
            #1;
            if (expQ.size() > 0) begin
                mon = expQ.pop_front();
                checkOutput("user_r_empty", 32'(user_r_empty), 32'(mon.empty));
                checkOutput("user_r_eof", 32'(user_r_eof), 32'(mon.empty));
                checkOutput("user_w_full", 32'(user_w_full), 32'(mon.full));
                checkOutput("app_wr_strobe", 32'(app_wr_strobe), 32'(mon.strobe));
                if (mon.rdKnown) checkOutput("user_r_data", user_r_data, mon.rdata);
                if (mon.appKnown) checkOutput("app_rdata", app_rdata, mon.app);
                if (app_wr_strobe === 1'b1) begin
                    if (wrAddrQ.size() == 0) begin
                        checkOutput("unexpected strobe", 32'(app_wr_addr), 32'hFFFF_FFFF);
                    end else begin
                        checkOutput("app_wr_addr", 32'(app_wr_addr), 32'(wrAddrQ.pop_front()));
                    end
                end
            end
        end
    end

    initial begin
        int drainCycles;
        for (int i = 0; i < DEPTH; i++) mValid[i] = 1'b0;

        // Reset.
        repeat (3) applyStimulus(1, 0, 0, '0, 0, '0, '0);

        // Initialise the whole memory, starting with a seek combined with a
        // write.
        applyStimulus(0, 0, 1, $urandom, 1, '0, '0);
        for (int i = 1; i < DEPTH; i++) hostWrite($urandom);
        idle();

        // Seek to 3, write A1..A4, seek back and read them.
        seek(5'd3);
        for (int i = 0; i < 4; i++) hostWrite(32'hA1 + 32'(i));
        seek(5'd3);
        for (int i = 0; i < 4; i++) hostRead();
        idle();

        // End of memory: third write dropped; reads stop at the end.
        seek(5'd30);
        for (int i = 0; i < 3; i++) hostWrite(32'hB0 + 32'(i));
        seek(5'd30);
        for (int i = 0; i < 3; i++) hostRead();
        idle();

        // Seek combined with a write, then the next write lands at 8.
        applyStimulus(0, 0, 1, 32'h5A, 1, 5'd7, curApp);
        hostWrite(32'h6B);
        seek(5'd7);
        hostRead();
        hostRead();
        idle();

        // App port: read-first on the cycle of a host write at the same address.
        curApp = 5'd9;
        idle();
        applyStimulus(0, 0, 1, 32'hC3, 1, 5'd9, curApp);
        idle();
        idle();

        // quiesce in the middle of reading; afterwards reads restart at 0.
        seek(5'd12);
        hostRead();
        applyStimulus(1, 1, 0, '0, 0, '0, curApp);
        hostRead();
        hostRead();
        idle();

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 49) == 0, 1'($urandom), 1'($urandom), $urandom,
                          $urandom_range(0, 9) == 0, 5'($urandom), 5'($urandom));
        end
        idle();

        drainCycles = 0;
        while (expQ.size() > 0 && drainCycles < 20) begin
            @(posedge bus_clk);
            drainCycles++;
        end
        #2;
        checkOutput("expectations drained", 32'(expQ.size()), 32'd0);
        checkOutput("write strobes drained", 32'(wrAddrQ.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
